// File: rtl/cfg_loader_pkg.sv
// cfg_loader_pkg: shared state encoding and CRC-16-CCITT constants for the config loader
package cfg_loader_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    WRITE = 3'd2,
    GAP   = 3'd3,
    CRC   = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_t;
  localparam int CRC_W = 16;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
  localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;
endpackage

// File: rtl/cfg_crc16_serial.sv
// cfg_crc16_serial: bit-serial CRC-16-CCITT, one message bit per enabled cycle
module cfg_crc16_serial
  import cfg_loader_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);
  logic fb;
  assign fb = crc[CRC_W-1] ^ bit_in;
  // clr reseeds for a new load; en folds one bit in MSB-first
  always_ff @(posedge clk or posedge reset)
    if (reset) crc <= CRC_INIT;
    else if (clr) crc <= CRC_INIT;
    else if (en) crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
endmodule

// File: rtl/cfg_frame_loader.sv
// cfg_frame_loader: serial bitstream to config SRAM frames with word-line pulses and CRC check
module cfg_frame_loader
  import cfg_loader_pkg::*;
#(
  parameter int FRAME_W    = 8,
  parameter int NUM_FRAMES = 9,
  parameter int WL_PULSE   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic                  cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [FRAME_W-1:0]    sram_bl,
  output logic [NUM_FRAMES-1:0] sram_wl,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic                  cfg_err
);
  localparam int BW  = $clog2(FRAME_W + 1);
  localparam int FIW = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1;
  localparam int PW  = $clog2(WL_PULSE + 1);
  state_t             state;
  logic [FRAME_W-1:0] shreg, shreg_n;
  logic [BW-1:0]      bit_cnt;
  logic [FIW-1:0]     frame_idx;
  logic [PW-1:0]      pcnt;
  logic [CRC_W-1:0]   chk, chk_n, crc;
  logic [4:0]         crc_cnt;
  logic               fire, go;
  assign cfg_ready = state == SHIFT || state == CRC;
  assign fire      = cfg_valid && cfg_ready;
  assign go        = cfg_start && (state == IDLE || state == DONE || state == ERROR);
  assign shreg_n   = {shreg[FRAME_W-2:0], cfg_data};
  assign chk_n     = {chk[CRC_W-2:0], cfg_data};
  assign cfg_busy  = state == SHIFT || state == WRITE || state == GAP || state == CRC;
  assign cfg_done  = state == DONE;
  assign cfg_err   = state == ERROR;
  // word line decoded from registered state so an async reset drops it immediately
  assign sram_wl   = state == WRITE ? NUM_FRAMES'(1) << frame_idx : '0;
  cfg_crc16_serial u_crc (
    .clk    (clk),
    .reset  (reset),
    .clr    (go),
    .en     (fire && state == SHIFT),
    .bit_in (cfg_data),
    .crc    (crc)
  );
  // load sequencer: assemble frame, pulse word line, hold gap, then compare trailing CRC
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      frame_idx <= '0;
      pcnt      <= '0;
      chk       <= '0;
      crc_cnt   <= '0;
      sram_bl   <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: if (cfg_start) begin
          state     <= SHIFT;
          bit_cnt   <= '0;
          frame_idx <= '0;
          pcnt      <= '0;
          crc_cnt   <= '0;
        end
        SHIFT: if (fire) begin
          shreg <= shreg_n;
          if (bit_cnt == BW'(FRAME_W - 1)) begin
            bit_cnt <= '0;
            sram_bl <= shreg_n;
            state   <= WRITE;
          end else bit_cnt <= bit_cnt + 1'b1;
        end
        WRITE: if (pcnt == PW'(WL_PULSE - 1)) begin
          pcnt  <= '0;
          state <= GAP;
        end else pcnt <= pcnt + 1'b1;
        GAP: if (frame_idx == FIW'(NUM_FRAMES - 1)) state <= CRC;
        else begin
          frame_idx <= frame_idx + 1'b1;
          state     <= SHIFT;
        end
        CRC: if (fire) begin
          chk     <= chk_n;
          crc_cnt <= crc_cnt + 1'b1;
          if (crc_cnt == 5'd15) state <= chk_n == crc ? DONE : ERROR;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
